// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Generic pipeline stage register with a valid/ready handshake,
//            bubble-injecting flush and an optional two-entry skid buffer.
//            The payload (data) is held on flush; the control field is
//            cleared on flush and reset, and reads 0 whenever no entry is
//            presented.
// Ports    : clk, rst_n        - clock (rising edge), async active-low reset
//            i_flush           - kill held entries and this cycle's input
//            i_in_valid/o_in_ready, i_in_data, i_in_ctrl   - upstream side
//            o_out_valid/i_out_ready, o_out_data, o_out_ctrl - downstream
//            o_occupancy       - number of entries held (0..2)
// Params   : DATA_W, CTRL_W, SKID (1 = skid buffer, registered in_ready)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [CTRL_W-1:0] o_out_ctrl,
    output logic [1:0]        o_occupancy
);

    // Encoding equals the entry count so occupancy is the state itself.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_MAIN  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    if (SKID != 0) begin : g_skid
        state_t              r_state;
        state_t              w_state_nxt;
        logic                r_in_ready;
        logic [DATA_W-1:0]   r_main_data, w_main_data_nxt;
        logic [DATA_W-1:0]   r_skid_data, w_skid_data_nxt;
        logic [CTRL_W-1:0]   r_main_ctrl, w_main_ctrl_nxt;
        logic [CTRL_W-1:0]   r_skid_ctrl, w_skid_ctrl_nxt;
        logic                w_in_hs;
        logic                w_out_hs;

        assign w_in_hs  = i_in_valid && r_in_ready;
        assign w_out_hs = (r_state != S_EMPTY) && i_out_ready;

        always_comb begin
            w_state_nxt     = r_state;
            w_main_data_nxt = r_main_data;
            w_main_ctrl_nxt = r_main_ctrl;
            w_skid_data_nxt = r_skid_data;
            w_skid_ctrl_nxt = r_skid_ctrl;
            if (i_flush) begin
                // Input accepted this cycle is swallowed; data words hold.
                w_state_nxt     = S_EMPTY;
                w_main_ctrl_nxt = '0;
                w_skid_ctrl_nxt = '0;
            end else begin
                case (r_state)
                    S_EMPTY: begin
                        if (w_in_hs) begin
                            w_state_nxt     = S_MAIN;
                            w_main_data_nxt = i_in_data;
                            w_main_ctrl_nxt = i_in_ctrl;
                        end
                    end
                    S_MAIN: begin
                        if (w_in_hs && w_out_hs) begin
                            w_main_data_nxt = i_in_data;
                            w_main_ctrl_nxt = i_in_ctrl;
                        end else if (w_in_hs) begin
                            // Downstream stalled: park the new entry in skid.
                            w_state_nxt     = S_FULL;
                            w_skid_data_nxt = i_in_data;
                            w_skid_ctrl_nxt = i_in_ctrl;
                        end else if (w_out_hs) begin
                            w_state_nxt     = S_EMPTY;
                            w_main_ctrl_nxt = '0;
                        end
                    end
                    S_FULL: begin
                        // in_ready is low here, so only the output can move.
                        if (w_out_hs) begin
                            w_state_nxt     = S_MAIN;
                            w_main_data_nxt = r_skid_data;
                            w_main_ctrl_nxt = r_skid_ctrl;
                            w_skid_ctrl_nxt = '0;
                        end
                    end
                    default: begin
                        w_state_nxt     = S_EMPTY;
                        w_main_ctrl_nxt = '0;
                        w_skid_ctrl_nxt = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state     <= S_EMPTY;
                r_in_ready  <= 1'b1;
                r_main_data <= '0;
                r_main_ctrl <= '0;
                r_skid_data <= '0;
                r_skid_ctrl <= '0;
            end else begin
                r_state     <= w_state_nxt;
                // Registered copy of (state != FULL): breaks out_ready -> in_ready.
                r_in_ready  <= (w_state_nxt != S_FULL);
                r_main_data <= w_main_data_nxt;
                r_main_ctrl <= w_main_ctrl_nxt;
                r_skid_data <= w_skid_data_nxt;
                r_skid_ctrl <= w_skid_ctrl_nxt;
            end
        end

        assign o_in_ready  = r_in_ready;
        assign o_out_valid = (r_state != S_EMPTY);
        assign o_out_data  = r_main_data;
        assign o_out_ctrl  = r_main_ctrl;
        assign o_occupancy = r_state;
    end else begin : g_noskid
        logic                r_valid;
        logic [DATA_W-1:0]   r_data;
        logic [CTRL_W-1:0]   r_ctrl;
        logic                w_in_ready;
        logic                w_in_hs;

        // Legacy stall behaviour: accept when empty or draining this cycle.
        assign w_in_ready = !r_valid || i_out_ready;
        assign w_in_hs    = i_in_valid && w_in_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_ctrl  <= '0;
            end else if (i_flush) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end else if (w_in_hs) begin
                r_valid <= 1'b1;
                r_data  <= i_in_data;
                r_ctrl  <= i_in_ctrl;
            end else if (r_valid && i_out_ready) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end
        end

        assign o_in_ready  = w_in_ready;
        assign o_out_valid = r_valid;
        assign o_out_data  = r_data;
        assign o_out_ctrl  = r_ctrl;
        assign o_occupancy = {1'b0, r_valid};
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Directed self-checking bench for pipe_stage_reg. Instance a_*
//            uses the skid buffer (SKID=1), instance b_* the single-entry
//            variant (SKID=0). Expected values are hand-derived constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 8;

    logic clk;
    logic rst_n;

    logic              a_flush, a_iv, a_ird, a_ov, a_ordy;
    logic [DATA_W-1:0] a_id, a_od;
    logic [CTRL_W-1:0] a_ic, a_oc;
    logic [1:0]        a_occ;

    logic              b_flush, b_iv, b_ird, b_ov, b_ordy;
    logic [DATA_W-1:0] b_id, b_od;
    logic [CTRL_W-1:0] b_ic, b_oc;
    logic [1:0]        b_occ;

    int n_tests;
    int n_fail;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) u_dut_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (a_flush),
        .i_in_valid  (a_iv),
        .o_in_ready  (a_ird),
        .i_in_data   (a_id),
        .i_in_ctrl   (a_ic),
        .o_out_valid (a_ov),
        .i_out_ready (a_ordy),
        .o_out_data  (a_od),
        .o_out_ctrl  (a_oc),
        .o_occupancy (a_occ)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) u_dut_noskid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (b_flush),
        .i_in_valid  (b_iv),
        .o_in_ready  (b_ird),
        .i_in_data   (b_id),
        .i_in_ctrl   (b_ic),
        .o_out_valid (b_ov),
        .i_out_ready (b_ordy),
        .o_out_data  (b_od),
        .o_out_ctrl  (b_oc),
        .o_occupancy (b_occ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        a_flush = 0; a_iv = 0; a_ordy = 0; a_id = '0; a_ic = '0;
        b_flush = 0; b_iv = 0; b_ordy = 0; b_id = '0; b_ic = '0;

        // ---------------- reset state ----------------
        #1;
        check_eq("rst_a_ov",   a_ov,  0);
        check_eq("rst_a_oc",   a_oc,  0);
        check_eq("rst_a_od",   a_od,  0);
        check_eq("rst_a_occ",  a_occ, 0);
        check_eq("rst_b_ov",   b_ov,  0);
        check_eq("rst_b_occ",  b_occ, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_a_ird", a_ird, 1);
        check_eq("post_rst_b_ird", b_ird, 1);

        // ---------------- streaming, SKID=1 ----------------
        a_ordy = 1;
        for (int i = 1; i <= 16; i++) begin
            a_iv = 1; a_id = 64'(i); a_ic = 8'(i);
            #1;
            check_eq("stream_ird", a_ird, 1);
            tick();
            check_eq("stream_ov",   a_ov, 1);
            check_eq("stream_data", a_od, 64'(i));
        end
        a_iv = 0;
        tick();
        check_eq("stream_drain_ov",  a_ov,  0);
        check_eq("stream_drain_oc",  a_oc,  0);
        check_eq("stream_drain_occ", a_occ, 0);

        // ---------------- backpressure, SKID=1 ----------------
        a_iv = 1; a_id = 64'hA; a_ic = 8'h0A;
        tick();
        check_eq("bp_A_presented", a_od, 64'hA);
        a_ordy = 0;
        a_id = 64'hB; a_ic = 8'h0B;
        #1;
        check_eq("bp_ird_before_B", a_ird, 1);
        tick();
        a_id = 64'hC; a_ic = 8'h0C;
        check_eq("bp_occ_full", a_occ, 2);
        check_eq("bp_ird_full", a_ird, 0);
        check_eq("bp_hold_A1",  a_od,  64'hA);
        tick();
        check_eq("bp_hold_A2",  a_od,  64'hA);
        check_eq("bp_occ_2b",   a_occ, 2);
        tick();
        check_eq("bp_hold_A3",  a_od,  64'hA);
        a_ordy = 1;
        tick();
        check_eq("bp_out_B",     a_od,  64'hB);
        check_eq("bp_out_B_ctl", a_oc,  8'h0B);
        check_eq("bp_occ_1",     a_occ, 1);
        check_eq("bp_ird_back",  a_ird, 1);
        tick();
        a_iv = 0;
        check_eq("bp_out_C",   a_od,  64'hC);
        check_eq("bp_occ_C",   a_occ, 1);
        tick();
        check_eq("bp_empty_ov",  a_ov,  0);
        check_eq("bp_empty_occ", a_occ, 0);

        // ---------------- flush in FULL ----------------
        a_ordy = 0;
        a_iv = 1; a_id = 64'h11; a_ic = 8'h3C;
        tick();
        a_id = 64'h22;
        tick();
        check_eq("fl_full_occ", a_occ, 2);
        check_eq("fl_full_oc",  a_oc,  8'h3C);
        a_flush = 1; a_id = 64'h33;
        tick();
        a_flush = 0; a_iv = 0;
        check_eq("fl_ov",   a_ov,  0);
        check_eq("fl_oc",   a_oc,  0);
        check_eq("fl_occ",  a_occ, 0);
        check_eq("fl_ird",  a_ird, 1);
        a_ordy = 1;
        tick();
        check_eq("fl_nothing1", a_ov, 0);
        tick();
        check_eq("fl_nothing2", a_ov, 0);

        // ---------------- flush in MAIN with accepted input ----------------
        a_ordy = 0;
        a_iv = 1; a_id = 64'h44; a_ic = 8'h5A;
        tick();
        a_flush = 1; a_id = 64'h55; a_ic = 8'h66;
        #1;
        check_eq("flm_ird", a_ird, 1);
        tick();
        a_flush = 0; a_iv = 0;
        check_eq("flm_ov",        a_ov,  0);
        check_eq("flm_occ",       a_occ, 0);
        check_eq("flm_oc",        a_oc,  0);
        check_eq("flm_data_hold", a_od,  64'h44);
        a_ordy = 1;
        tick();
        check_eq("flm_nothing", a_ov, 0);

        // ---------------- flush with output handshake ----------------
        a_iv = 1; a_id = 64'h77; a_ic = 8'h01;
        tick();
        a_iv = 0;
        a_flush = 1;
        #1;
        check_eq("flo_deliver_ov", a_ov, 1);
        check_eq("flo_deliver_od", a_od, 64'h77);
        tick();
        a_flush = 0;
        check_eq("flo_after_ov", a_ov, 0);
        tick();
        check_eq("flo_after2_ov", a_ov, 0);

        // ---------------- asynchronous reset mid-stream ----------------
        a_ordy = 0;
        a_iv = 1; a_id = 64'h99; a_ic = 8'hFF;
        tick();
        a_iv = 0;
        check_eq("ar_pre_ov", a_ov, 1);
        check_eq("ar_pre_oc", a_oc, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_ov",  a_ov,  0);
        check_eq("ar_oc",  a_oc,  0);
        check_eq("ar_occ", a_occ, 0);
        check_eq("ar_od",  a_od,  0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("ar_ird", a_ird, 1);
        check_eq("ar_ov2", a_ov,  0);

        // ---------------- SKID=0 stall ----------------
        b_ordy = 0;
        b_iv = 1; b_id = 64'hAA; b_ic = 8'h12;
        tick();
        check_eq("ns_X_ov",  b_ov,  1);
        check_eq("ns_X_od",  b_od,  64'hAA);
        check_eq("ns_X_occ", b_occ, 1);
        b_id = 64'hBB; b_ic = 8'h34;
        #1;
        check_eq("ns_stall_ird", b_ird, 0);
        tick();
        check_eq("ns_X_stable", b_od, 64'hAA);
        check_eq("ns_X_ctl",    b_oc, 8'h12);
        b_ordy = 1;
        #1;
        check_eq("ns_ird_comb", b_ird, 1);
        tick();
        b_iv = 0;
        check_eq("ns_Y_od",  b_od,  64'hBB);
        check_eq("ns_Y_oc",  b_oc,  8'h34);
        check_eq("ns_Y_occ", b_occ, 1);
        tick();
        check_eq("ns_empty_ov", b_ov, 0);
        check_eq("ns_empty_oc", b_oc, 0);

        // ---------------- SKID=0 streaming ----------------
        for (int i = 0; i < 4; i++) begin
            b_iv = 1; b_id = 64'(32'h100 + i); b_ic = 8'h01;
            tick();
            check_eq("ns_stream", b_od, 64'(32'h100 + i));
        end
        b_iv = 0;
        b_flush = 1;
        tick();
        b_flush = 0;
        check_eq("ns_flush_ov", b_ov, 0);
        check_eq("ns_flush_oc", b_oc, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
